// File: rtl/interval_timer.sv
// Programmable interval timer: loadable down counter with one-shot and
// periodic (auto-reload) modes, pause/hold, terminal-count pulse and done flag.
module interval_timer #(
   parameter int                 WIDTH       = 4,
   parameter logic [WIDTH-1:0]   RESET_COUNT = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             tick,
   input  logic             periodic,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tc_pulse,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic             busy_q, done_q, tc_q, err_q;
   logic             tc_d, err_d;

   // Count of one is the terminal value; reaching zero through a decrement
   // only happens in one-shot mode, so the counter can never wrap.
   logic at_terminal;
   assign at_terminal = (count_q <= WIDTH'(1));

   // NOTE: every signal is given a default before the decision tree, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      tc_d     = 1'b0;
      err_d    = 1'b0;

      if (stop) begin
         state_d = IDLE;
         count_d = RESET_COUNT;
      end else if (start) begin
         if (load_val != '0) begin
            reload_d = load_val;
            mode_d   = periodic;
            count_d  = load_val;
            state_d  = RUN;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               count_d = RESET_COUNT;
            end
            RUN: begin
               if (pause) begin
                  state_d = HOLD;
               end else if (tick) begin
                  if (at_terminal) begin
                     tc_d = 1'b1;
                     if (mode_q) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = DONE;
                     end
                  end else begin
                     count_d = count_q - WIDTH'(1);
                  end
               end
            end
            HOLD: begin
               // The resume cycle deliberately ignores any tick.
               if (!pause) state_d = RUN;
            end
            DONE: begin
               count_d = '0;
            end
            default: begin
               state_d = IDLE;
               count_d = RESET_COUNT;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= RESET_COUNT;
         reload_q <= '0;
         mode_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         tc_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         busy_q   <= (state_d == RUN) || (state_d == HOLD);
         done_q   <= (state_d == DONE);
         tc_q     <= tc_d;
         err_q    <= err_d;
      end
   end

   assign count    = count_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign tc_pulse = tc_q;
   assign err      = err_q;

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer: the driver pushes hand-computed
// post-edge responses, the monitor pops and compares after each clock edge.
module tb_interval_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, stop, pause, tick, periodic;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       busy, done, tc_pulse, err;

   typedef struct {
      string      name;
      logic [7:0] val;   // {count, busy, done, tc_pulse, err}
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   interval_timer #(.WIDTH(4), .RESET_COUNT(4'd0)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .tick     (tick),
      .periodic (periodic),
      .load_val (load_val),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .tc_pulse (tc_pulse),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got count=%0d busy=%b done=%b tc=%b err=%b, want count=%0d busy=%b done=%b tc=%b err=%b",
                  name, got[7:4], got[3], got[2], got[1], got[0],
                  want[7:4], want[3], want[2], want[1], want[0]);
      end
   endtask

   // One cycle of stimulus plus the response expected after the next edge.
   task automatic step(input string name,
                       input logic st, input logic sp, input logic pa, input logic tk,
                       input logic per, input logic [3:0] lv,
                       input logic [3:0] ec, input logic eb, input logic ed,
                       input logic etc, input logic ee);
      exp_t e;
      @(negedge clk);
      start = st; stop = sp; pause = pa; tick = tk; periodic = per; load_val = lv;
      e.name = name;
      e.val  = {ec, eb, ed, etc, ee};
      sb.push_back(e);
   endtask

   // Monitor: every edge with an outstanding expectation is compared.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.name, {count, busy, done, tc_pulse, err}, e.val);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 0; stop = 0; pause = 0; tick = 0; periodic = 0; load_val = 4'd0;
      #1;
      check("reset_state", {count, busy, done, tc_pulse, err}, 8'h00);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      //    name          st sp pa tk per lv     cnt  b  d  tc er
      // One-shot, load 5, tick held high.
      step("os_load",     1, 0, 0, 1, 0, 4'd5, 4'd5, 1, 0, 0, 0);
      step("os_4",        0, 0, 0, 1, 0, 4'd0, 4'd4, 1, 0, 0, 0);
      step("os_3",        0, 0, 0, 1, 0, 4'd0, 4'd3, 1, 0, 0, 0);
      step("os_2",        0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("os_1",        0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 0, 0);
      step("os_tc",       0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1, 0);
      step("os_done_a",   0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 0, 0);
      step("os_done_b",   0, 0, 1, 1, 0, 4'd0, 4'd0, 0, 1, 0, 0);

      // Periodic, load 3, started from DONE, ten ticks.
      step("per_load",    1, 0, 0, 1, 1, 4'd3, 4'd3, 1, 0, 0, 0);
      step("per_2a",      0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("per_1a",      0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 0, 0);
      step("per_tc_a",    0, 0, 0, 1, 0, 4'd0, 4'd3, 1, 0, 1, 0);
      step("per_2b",      0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("per_1b",      0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 0, 0);
      step("per_tc_b",    0, 0, 0, 1, 0, 4'd0, 4'd3, 1, 0, 1, 0);
      step("per_2c",      0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("per_1c",      0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 0, 0);
      step("per_tc_c",    0, 0, 0, 1, 0, 4'd0, 4'd3, 1, 0, 1, 0);
      step("per_2d",      0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("per_stop",    0, 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0);

      // Pause and tick gating, load 4, tick alternating.
      step("pz_load",     1, 0, 0, 0, 0, 4'd4, 4'd4, 1, 0, 0, 0);
      step("pz_3",        0, 0, 0, 1, 0, 4'd0, 4'd3, 1, 0, 0, 0);
      step("pz_3_idle",   0, 0, 0, 0, 0, 4'd0, 4'd3, 1, 0, 0, 0);
      step("pz_2",        0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("pz_hold_a",   0, 0, 1, 1, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("pz_hold_b",   0, 0, 1, 0, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("pz_hold_c",   0, 0, 1, 1, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("pz_resume",   0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, 0);
      step("pz_1",        0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 0, 0);
      step("pz_1_idle",   0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, 0);
      step("pz_tc",       0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1, 0);
      step("pz_done",     0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0, 0);

      // Collisions.
      step("col_load6",   1, 0, 0, 0, 0, 4'd6, 4'd6, 1, 0, 0, 0);
      step("col_5",       0, 0, 0, 1, 0, 4'd0, 4'd5, 1, 0, 0, 0);
      step("col_startstop",1,1, 0, 1, 0, 4'd9, 4'd0, 0, 0, 0, 0);
      step("idle_tick",   0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0);
      step("idle_pause",  0, 0, 1, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0);
      step("idle_err",    1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 1);
      step("col_load2",   1, 0, 0, 0, 0, 4'd2, 4'd2, 1, 0, 0, 0);
      step("col_1",       0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 0, 0);
      step("col_retrig7", 1, 0, 0, 1, 0, 4'd7, 4'd7, 1, 0, 0, 0);
      step("col_err",     1, 0, 0, 1, 1, 4'd0, 4'd7, 1, 0, 0, 1);
      step("col_6",       0, 0, 0, 1, 0, 4'd0, 4'd6, 1, 0, 0, 0);

      // Zero-load start keeps one-shot mode, then retrigger from DONE.
      step("md_load2",    1, 0, 0, 0, 0, 4'd2, 4'd2, 1, 0, 0, 0);
      step("md_err",      1, 0, 0, 0, 1, 4'd0, 4'd2, 1, 0, 0, 1);
      step("md_1",        0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 0, 0);
      step("md_tc",       0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1, 0);
      step("rt_load2",    1, 0, 0, 0, 0, 4'd2, 4'd2, 1, 0, 0, 0);
      step("rt_1",        0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 0, 0);
      step("rt_tc",       0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1, 0);

      // Reset asserted mid-RUN with count 9.
      step("rs_load9",    1, 0, 0, 0, 0, 4'd9, 4'd9, 1, 0, 0, 0);
      step("rs_hold9",    0, 0, 0, 0, 0, 4'd0, 4'd9, 1, 0, 0, 0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("rs_async", {count, busy, done, tc_pulse, err}, 8'h00);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      step("rs_idle",     0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, 0);

      // Load of 1: periodic reloads every tick, one-shot ends at once.
      step("p1_load",     1, 0, 0, 0, 1, 4'd1, 4'd1, 1, 0, 0, 0);
      step("p1_tc_a",     0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 1, 0);
      step("p1_tc_b",     0, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, 1, 0);
      step("o1_load",     1, 0, 0, 0, 0, 4'd1, 4'd1, 1, 0, 0, 0);
      step("o1_tc",       0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1, 0);
      step("o1_stop",     0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0);

      @(negedge clk);
      start = 0; stop = 0; pause = 0; tick = 0;
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 8'(sb.size()), 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
Programmable interval timer built around a loadable down counter. It loads a start value, decrements on each qualified tick, and flags terminal count. It runs in one-shot or periodic (auto-reload) mode. It sits downstream of the prescaler/tick source and upstream of event and interrupt logic that consumes tc_pulse/done.

Parameters:
WIDTH, 4, width of counter, load value and count output
RESET_COUNT, 0, value of count in reset and IDLE

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  load load_val into counter and begin or retrigger counting
stop  input  1  abort; return to IDLE
pause  input  1  freeze counter while high (RUN only)
tick  input  1  count enable; one decrement per cycle with tick=1
periodic  input  1  sampled at start: 1 = auto-reload, 0 = one-shot
load_val  input  WIDTH  initial and reload count, sampled at start
count  output  WIDTH  current counter value (registered)
busy  output  1  high in RUN or HOLD
done  output  1  one-shot completed; level, held until start or stop
tc_pulse  output  1  one-cycle pulse on each terminal count
err  output  1  one-cycle pulse when start is given with load_val == 0

Behaviour:
- Reset is asynchronous, active-high. While reset=1: state=IDLE, count=RESET_COUNT, reload register=0, mode=0, busy=0, done=0, tc_pulse=0, err=0. The first state change is at the first posedge after reset deasserts.
- All outputs are registered. tc_pulse and err default to 0 every cycle unless set.
- States: IDLE, RUN, HOLD, DONE. busy = (RUN or HOLD). done = (DONE).
- Priority each cycle: stop > start > pause > tick.
- stop (any state): next state IDLE, count=RESET_COUNT, no tc_pulse, done cleared.
- start with load_val != 0 (any state, stop=0): reload reg <= load_val, mode <= periodic, count <= load_val, next state RUN. Same-cycle tick is ignored. Retrigger from RUN/HOLD/DONE behaves identically.
- start with load_val == 0: err=1 for one cycle; state, count and mode are unchanged.
- RUN, pause=1: next state HOLD; count frozen even if tick=1.
- HOLD: count frozen. pause=0 returns to RUN next cycle; a tick in that same cycle is ignored.
- RUN, pause=0, tick=1, count > 1: count <= count - 1.
- RUN, tick=1, count == 1, mode one-shot: count <= 0, next state DONE, tc_pulse=1 in the cycle count first reads 0.
- RUN, tick=1, count == 1, mode periodic: count <= reload value, stay RUN, tc_pulse=1 in the cycle count first reads reload value. The period is exactly reload value ticks.
- tick=0 in RUN: no change.
- DONE: count held at 0, done=1; tick and pause are ignored; leaves only via start or stop.
- IDLE: tick and pause are ignored; count=RESET_COUNT.
- Arithmetic is unsigned WIDTH-bit. Count never decrements below 0 and never wraps to all-ones; terminal handling at count==1 guarantees this.
- Reset mid-count: immediate return to reset values. The mode and reload register are lost.
- Latency: start to first decrement-eligible cycle is 1 clock. Terminal tick to tc_pulse visible is 1 clock (registered).

Test Plan:
- Reset asserted mid-RUN with count=9 -> count=0, busy=0, done=0, tc_pulse=0 immediately (before the next clk edge); IDLE after release.
- One-shot: start, load_val=5, periodic=0, tick held high -> count 5,4,3,2,1,0 on successive cycles; tc_pulse=1 only in the cycle count=0; done=1 and busy=0 thereafter; further ticks leave count=0.
- Periodic: start, load_val=3, periodic=1, tick every cycle for 10 cycles -> count 3,2,1,3,2,1,3,...; tc_pulse high on each return to 3, spaced 3 cycles apart; done stays 0.
- Pause and tick gating: load 4, tick alternating 1/0, pause=1 for 3 cycles at count=2 -> count holds 2 through HOLD and the resume cycle, then continues 1,0 with a single tc_pulse.
- Collisions: start and stop together in RUN -> IDLE, count=0. Start with load_val=7 at count=1 with tick=1 -> count=7, no tc_pulse. Start with load_val=0 -> err pulse only, count unchanged.
- Retrigger from DONE: after a one-shot completes, start load_val=2 -> done drops next cycle, busy=1, count 2,1,0, new tc_pulse.
